mp3_sci_reader: RTL and testbench

//  SCI register read-back engine for the VS10xx decoder, the read side of the MP3 SPI link.
//  On request it issues an SCI READ (opcode 8'h03) over CS/SCLK/MOSI and shifts the
//  16-bit register value in on MISO. Game logic polls decoder status through it:
//  SCI_DECODE_TIME for the play timer, SCI_HDAT1 for format checks. Shares DREQ with
//  the BGM path; an external mux grants the SPI pins.

---
 rtl/mp3_sci_reader.sv | 228 ++++++++++++++++++++++
 tb/tb_mp3_sci_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_sci_reader.sv
// mp3_sci_reader: SCI register read-back engine for the VS10xx decoder.
// On req it waits for DREQ, lowers CS, sends the SCI READ command (8'h03,
// 4'h0, addr) MSB-first and shifts the 16-bit register value in on MISO.
// Ports:
//   mp3_clk, rst        clock, synchronous active-high reset
//   req, addr[3:0]      start request (sampled in IDLE) and SCI address
//   busy, done, err     status; done/err are one-cycle pulses
//   rdata[15:0]         last value read, held until the next done
//   DREQ, MISO          decoder ready and serial data from decoder
//   CS, SCLK, MOSI      SCI chip select (active low), serial clock, data out
// Configuration: define SCI_RD_TIMEOUT_EN to abort WAIT_DREQ after TIMEOUT
// cycles with done+err; otherwise WAIT_DREQ waits forever and err is 0.
module mp3_sci_reader #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        mp3_clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  input  logic        DREQ,
  input  logic        MISO,
  output logic        CS,
  output logic        SCLK,
  output logic        MOSI
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned BIT_W = 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // Reject parameter values the timing scheme cannot honour.
  if (CLK_DIV < 2 || CS_GAP < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("mp3_sci_reader: CLK_DIV must be >= 2, CS_GAP and TIMEOUT >= 1");
  end

  logic [2:0]       r_state, w_state_nxt;
  logic [15:0]      r_cmd, w_cmd_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt;
  logic [15:0]      r_shift, w_shift_nxt;
  logic [15:0]      r_rdata, w_rdata_nxt;
  logic             r_cs, w_cs_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_mosi, w_mosi_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

`ifdef SCI_RD_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic             r_to_hit, w_to_hit_nxt;
  logic             r_err, w_err_nxt;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_gap_nxt   = r_gap;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_rdata_nxt = r_rdata;
    w_cs_nxt    = r_cs;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef SCI_RD_TIMEOUT_EN
    w_to_cnt_nxt = r_to_cnt;
    w_to_hit_nxt = r_to_hit;
    w_err_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_cmd_nxt   = {8'h03, 4'h0, addr};
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_WAIT;
`ifdef SCI_RD_TIMEOUT_EN
          w_to_cnt_nxt = '0;
          w_to_hit_nxt = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (DREQ) begin
          w_cs_nxt    = 1'b0;
          w_mosi_nxt  = r_cmd[15];
          w_gap_nxt   = '0;
          w_state_nxt = S_SETUP;
        end
`ifdef SCI_RD_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_to_hit_nxt = 1'b1;
          w_state_nxt  = S_FINISH;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
`endif
      end
      S_SETUP: begin
        if (r_gap == GAP_W'(CS_GAP - 1)) begin
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      S_SHIFT: begin
        w_div_nxt = r_div + DIV_W'(1);
        if (r_div == DIV_W'(CLK_DIV - 1)) begin
          // Rising SCLK edge; the response half samples MISO on the same edge.
          w_sclk_nxt = 1'b1;
          if (r_bit[4]) begin
            w_shift_nxt = {r_shift[14:0], MISO};
          end
        end else if (r_div == DIV_W'(2 * CLK_DIV - 1)) begin
          // Falling SCLK edge starts the next bit's low phase; MOSI moves here only.
          w_sclk_nxt = 1'b0;
          w_div_nxt  = '0;
          if (r_bit == BIT_W'(31)) begin
            w_mosi_nxt  = 1'b0;
            w_gap_nxt   = '0;
            w_state_nxt = S_HOLD;
          end else begin
            w_bit_nxt  = r_bit + BIT_W'(1);
            w_mosi_nxt = (r_bit < BIT_W'(15)) ? r_cmd[4'(4'd14 - r_bit[3:0])] : 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (r_gap == GAP_W'(CS_GAP - 1)) begin
          w_cs_nxt    = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      S_FINISH: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
`ifdef SCI_RD_TIMEOUT_EN
        if (r_to_hit) begin
          w_err_nxt = 1'b1;
        end else begin
          w_rdata_nxt = r_shift;
        end
`else
        w_rdata_nxt = r_shift;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge mp3_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_gap   <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SCI_RD_TIMEOUT_EN
      r_to_cnt <= '0;
      r_to_hit <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_gap   <= w_gap_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_rdata <= w_rdata_nxt;
      r_cs    <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef SCI_RD_TIMEOUT_EN
      r_to_cnt <= w_to_cnt_nxt;
      r_to_hit <= w_to_hit_nxt;
      r_err    <= w_err_nxt;
`endif
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign CS    = r_cs;
  assign SCLK  = r_sclk;
  assign MOSI  = r_mosi;
`ifdef SCI_RD_TIMEOUT_EN
  assign err   = r_err;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_mp3_sci_reader.sv
// Scoreboard bench for mp3_sci_reader: stimulus pushes expected read results
// and expected port states; one monitor process compares them and checks SCI
// pin timing, and a behavioural decoder answers on MISO.
module tb_mp3_sci_reader;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CS_GAP  = 4;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned XFER    = 2 * CS_GAP + 64 * CLK_DIV + 1;

  logic        mp3_clk;
  logic        rst;
  logic        req;
  logic [3:0]  addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic        DREQ;
  logic        MISO;
  logic        CS;
  logic        SCLK;
  logic        MOSI;

  mp3_sci_reader #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
    .mp3_clk(mp3_clk), .rst(rst), .req(req), .addr(addr),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .DREQ(DREQ), .MISO(MISO), .CS(CS), .SCLK(SCLK), .MOSI(MOSI)
  );

  initial mp3_clk = 1'b0;
  always #5 mp3_clk = ~mp3_clk;

  typedef struct {
    int unsigned cyc;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] mosi;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    logic        busy;
    logic        cs;
    logic        sclk;
    logic        done;
    logic        chk_rdata;
    logic [15:0] rdata;
    string       name;
  } st_t;

  exp_t        exp_q[$];
  st_t         st_q[$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  int unsigned stall_cnt;
  int unsigned n_exp;
  int unsigned done_cnt;
  logic [15:0] cur_resp;
  logic        end_req;
  logic        fin;
  int          rises;
  int          cs_low_cyc;
  int          fall_cyc;
  logic [31:0] mosi_cap;
  logic        prev_cs;
  logic        prev_sclk;
  logic        prev_mosi;
  exp_t        m_e;
  st_t         m_s;

  initial cyc = 0;
  always @(posedge mp3_clk) cyc <= cyc + 1;

  // Decoder model: response bits are presented for SCLK rises 16..31.
  always_comb begin
    MISO = 1'b0;
    if (rises >= 16 && rises < 32) MISO = cur_resp[4'(31 - rises)];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard, expected-state checks, pin timing, end of run.
  initial begin
    checks = 0; errors = 0; done_cnt = 0; fin = 1'b0;
    rises = 0; cs_low_cyc = 0; fall_cyc = 0; mosi_cap = '0;
    prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
  end

  always @(negedge mp3_clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        m_e = exp_q.pop_front();
        chk("done_cycle", cyc, m_e.cyc);
        chk("rdata", 32'(rdata), 32'(m_e.rdata));
        chk("err", 32'(err), 32'(m_e.err));
        if (!m_e.err) begin
          chk("mosi_cmd", 32'(mosi_cap[31:16]), 32'(m_e.mosi));
          chk("mosi_pad", 32'(mosi_cap[15:0]), 32'(0));
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      m_e = exp_q.pop_front();
      chk("done_missing", cyc, m_e.cyc);
    end

    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      m_s = st_q.pop_front();
      if (m_s.cyc < cyc) begin
        chk({"stale_", m_s.name}, cyc, m_s.cyc);
      end else begin
        chk({m_s.name, "_busy"}, 32'(busy), 32'(m_s.busy));
        chk({m_s.name, "_cs"}, 32'(CS), 32'(m_s.cs));
        chk({m_s.name, "_sclk"}, 32'(SCLK), 32'(m_s.sclk));
        chk({m_s.name, "_done"}, 32'(done), 32'(m_s.done));
        if (m_s.chk_rdata) chk({m_s.name, "_rdata"}, 32'(rdata), 32'(m_s.rdata));
      end
    end

    if (rst) begin
      rises = 0; cs_low_cyc = 0; fall_cyc = 0;
    end else begin
      if (!CS) begin
        if (prev_cs) begin
          cs_low_cyc = 1; rises = 0; mosi_cap = '0; fall_cyc = 0;
        end else begin
          cs_low_cyc++;
        end
      end
      if (SCLK && !prev_sclk) begin
        chk("mosi_stable_at_rise", 32'(MOSI), 32'(prev_mosi));
        chk("cs_low_at_rise", 32'(CS), 32'(0));
        if (rises == 0) chk("cs_setup_gap", 32'(cs_low_cyc - 1 >= int'(CS_GAP)), 32'(1));
        mosi_cap = {mosi_cap[30:0], MOSI};
        rises++;
      end
      if (!SCLK && prev_sclk) fall_cyc = 1;
      else if (fall_cyc > 0) fall_cyc++;
      if (CS && !prev_cs) begin
        chk("sclk_rises_per_window", 32'(rises), 32'(32));
        chk("cs_hold_gap", 32'(fall_cyc - 1 >= int'(CS_GAP)), 32'(1));
        chk("sclk_low_at_cs_rise", 32'(SCLK), 32'(0));
      end
    end
    prev_cs = CS; prev_sclk = SCLK; prev_mosi = MOSI;

    if (end_req && !fin) begin
      fin = 1'b1;
      chk("pending_results", 32'(exp_q.size()), 32'(0));
      chk("pending_states", 32'(st_q.size()), 32'(0));
      chk("stalled_waits", stall_cnt, 32'(0));
      chk("done_count", done_cnt, n_exp);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic st_push(input int unsigned at, input logic b, input logic c,
                         input logic s, input logic d, input logic cr,
                         input logic [15:0] rd, input string nm);
    st_t t;
    t.cyc = at; t.busy = b; t.cs = c; t.sclk = s; t.done = d;
    t.chk_rdata = cr; t.rdata = rd; t.name = nm;
    st_q.push_back(t);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 3000) begin
      @(negedge mp3_clk);
      g++;
    end
    if (g >= 3000) stall_cnt++;
  endtask

  // hold: 0 = DREQ already high, >0 = DREQ raised after hold cycles, <0 = never.
  task automatic issue(input logic [3:0] a, input logic [15:0] resp, input int hold,
                       input bit push, input bit exp_err, input logic [15:0] exp_rd);
    int unsigned c;
    int unsigned lat;
    exp_t e;
    wait_idle();
    cur_resp = resp;
    DREQ = (hold == 0);
    addr = a;
    req = 1'b1;
    c = cyc;
    if (exp_err) lat = TIMEOUT + 1;
    else lat = ((hold <= 1) ? 1 : int'(hold)) + XFER;
    if (push) begin
      e.cyc = c + 1 + lat; e.rdata = exp_rd; e.err = exp_err; e.mosi = {8'h03, 4'h0, a};
      exp_q.push_back(e);
      n_exp++;
    end
    st_push(c + 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "busy_after_accept");
    @(negedge mp3_clk);
    req = 1'b0;
    if (hold < 0) begin
      for (int i = 1; i <= int'(TIMEOUT); i++) begin
        st_push(cyc + 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "cs_idle_timeout");
        @(negedge mp3_clk);
      end
    end else if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        st_push(cyc + 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, "cs_idle_no_dreq");
        @(negedge mp3_clk);
      end
      DREQ = 1'b1;
    end
  endtask

  initial begin
    int g;
    rst = 1'b1; req = 1'b0; DREQ = 1'b1; addr = 4'h0; cur_resp = 16'h0;
    end_req = 1'b0; stall_cnt = 0; n_exp = 0;
    repeat (3) @(negedge mp3_clk);
    st_push(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, "reset");
    @(negedge mp3_clk);
    rst = 1'b0;
    repeat (3) @(negedge mp3_clk);

    // Basic read, then a back-to-back read with DREQ low for 500 cycles.
    issue(4'h4, 16'hA55A, 0, 1'b1, 1'b0, 16'hA55A);
    issue(4'h7, 16'h1234, 500, 1'b1, 1'b0, 16'h1234);

    // Requests while busy are dropped; the address is latched at acceptance.
    issue(4'hB, 16'h0F0F, 0, 1'b1, 1'b0, 16'h0F0F);
    for (int k = 0; k < 5; k++) begin
      repeat (30) @(negedge mp3_clk);
      addr = 4'hF;
      req = 1'b1;
      @(negedge mp3_clk);
      req = 1'b0;
    end
    issue(4'hC, 16'hFFFF, 0, 1'b1, 1'b0, 16'hFFFF);

    // Reset in the middle of the response phase, then a fresh read.
    issue(4'h3, 16'hBEEF, 0, 1'b0, 1'b0, 16'h0);
    g = 0;
    while (rises < 21 && g < 2000) begin
      @(negedge mp3_clk);
      g++;
    end
    if (g >= 2000) stall_cnt++;
    rst = 1'b1;
    st_push(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, "reset_mid_shift");
    repeat (2) @(negedge mp3_clk);
    rst = 1'b0;
    @(negedge mp3_clk);
    issue(4'h3, 16'hBEEF, 0, 1'b1, 1'b0, 16'hBEEF);

`ifdef SCI_RD_TIMEOUT_EN
    // DREQ never rises: timeout gives done+err with rdata untouched.
    issue(4'h5, 16'h1111, -1, 1'b1, 1'b1, 16'hBEEF);
    wait_idle();
    DREQ = 1'b1;
`endif

    wait_idle();
    repeat (5) @(negedge mp3_clk);
    end_req = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
